// File: rtl/io_pkg.sv
// io_pkg: shared constants and types for the board-side I/O endpoint.
//   SEG_HEX     active-low seven-segment glyphs for hex digits 0-F, {dp,g,f,e,d,c,b,a}
//   SEG_E       'E' glyph used for decimal overflow
//   SEG_BLANK   all segments off
//   TUBE_DIGITS number of multiplexed digits on the tube
//   tube_t      registered anode/segment pair driven to the pins
package io_pkg;

  localparam int unsigned TUBE_DIGITS = 8;

  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // dp (bit 7) is always high, i.e. off
  localparam logic [7:0] SEG_HEX [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  typedef struct packed {
    logic [7:0] an;
    logic [7:0] seg;
  } tube_t;

endpackage

// File: rtl/debounce_sync.sv
// debounce_sync: two-flop synchroniser followed by a shared stability counter.
// The whole WIDTH-bit word is accepted at once after the synchronised value has
// differed from the accepted value, unchanged, for DEB_CYCLES consecutive samples.
//   clk, rst  system clock, synchronous active-high reset
//   raw       asynchronous input word
//   stable    debounced (accepted) word
module debounce_sync #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DEB_CYCLES = 200000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] stable
);

  localparam int unsigned CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] prev;
  logic [CNT_W-1:0] cnt;

  // Counter holds the number of identical consecutive samples that differ from stable;
  // a fresh differing value restarts the count at one.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      prev   <= '0;
      cnt    <= '0;
      stable <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      prev  <= sync2;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (sync2 != prev) begin
        cnt <= CNT_W'(1);
      end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/io_board_endpoint.sv
// io_board_endpoint: board-side end of the CPU I/O interface.
// Displays the last CPU I/O write on the 8-digit multiplexed tube and returns
// debounced switches plus a one-cycle confirm strobe to the CPU.
// Build option: define TUBE_DEC_EN to show the value as 8 decimal digits
// (sequential binary->BCD, 'E' on every digit above 99_999_999); otherwise hex.
//   clk, rst    system clock, synchronous active-high reset
//   io_we       CPU write strobe qualifying io_wdata
//   io_wdata    value to display
//   sw_raw      raw switches      -> sw_data   debounced switch word
//   conf_raw    raw confirm button -> conf_pulse one pulse per accepted press
//   tube_an     digit enables, active-low one-hot
//   tube_seg    segments {dp,g,f,e,d,c,b,a}, active-low
module io_board_endpoint #(
  parameter int unsigned SCAN_DIV   = 100000,
  parameter int unsigned DEB_CYCLES = 200000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        io_we,
  input  logic [31:0] io_wdata,
  input  logic [15:0] sw_raw,
  input  logic        conf_raw,
  output logic [15:0] sw_data,
  output logic        conf_pulse,
  output logic [7:0]  tube_an,
  output logic [7:0]  tube_seg
);

  import io_pkg::*;

  localparam int unsigned PRE_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W = $clog2(TUBE_DIGITS);

  logic [31:0] disp_reg;
  logic [31:0] disp_val;   // nibble-per-digit value currently shown
  logic        disp_err;   // force 'E' on every digit

  // CPU write capture
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_reg <= '0;
    end else if (io_we) begin
      disp_reg <= io_wdata;
    end
  end

`ifdef TUBE_DEC_EN
  logic [31:0] bin_sh;
  logic [31:0] bcd_sh;
  logic [31:0] bcd_adj;
  logic [4:0]  step;
  logic        busy;

  // Shift-add-3: bump every BCD digit >= 5 before the next shift
  always_comb begin
    bcd_adj = bcd_sh;
    for (int d = 0; d < 8; d++) begin
      if (bcd_sh[4*d +: 4] >= 4'd5) begin
        bcd_adj[4*d +: 4] = bcd_sh[4*d +: 4] + 4'd3;
      end
    end
  end

  // 32-step conversion; a new write restarts it, old result stays shown until done
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_sh   <= '0;
      bcd_sh   <= '0;
      step     <= '0;
      busy     <= 1'b0;
      disp_val <= '0;
      disp_err <= 1'b0;
    end else if (io_we) begin
      bin_sh <= io_wdata;
      bcd_sh <= '0;
      step   <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      {bcd_sh, bin_sh} <= {bcd_adj, bin_sh} << 1;
      step             <= step + 5'd1;
      if (step == 5'd31) begin
        busy     <= 1'b0;
        disp_val <= {bcd_adj[30:0], bin_sh[31]};
        disp_err <= disp_reg > 32'd99_999_999;
      end
    end
  end
`else
  assign disp_val = disp_reg;
  assign disp_err = 1'b0;
`endif

  // Digit scan
  logic [PRE_W-1:0] pre;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nxt;
  logic             pre_tc;
  logic [3:0]       nib;
  tube_t            tube_nxt;

  assign pre_tc  = (pre == PRE_W'(SCAN_DIV - 1));
  assign idx_nxt = pre_tc ? idx + IDX_W'(1) : idx;
  assign nib     = disp_val[{idx_nxt, 2'b00} +: 4];

  always_comb begin
    tube_nxt.an  = ~(8'h01 << idx_nxt);
    tube_nxt.seg = disp_err ? SEG_E : SEG_HEX[nib];
  end

  // Anode and segments leave the same register stage, so digits never ghost
  always_ff @(posedge clk) begin
    if (rst) begin
      pre      <= '0;
      idx      <= '0;
      tube_an  <= 8'hFE;
      tube_seg <= SEG_HEX[0];
    end else begin
      pre      <= pre_tc ? '0 : pre + PRE_W'(1);
      idx      <= idx_nxt;
      tube_an  <= tube_nxt.an;
      tube_seg <= tube_nxt.seg;
    end
  end

  // Debounced inputs
  logic conf_acc;
  logic conf_acc_q;

  debounce_sync #(.WIDTH(16), .DEB_CYCLES(DEB_CYCLES)) u_deb_sw (
    .clk    (clk),
    .rst    (rst),
    .raw    (sw_raw),
    .stable (sw_data)
  );

  debounce_sync #(.WIDTH(1), .DEB_CYCLES(DEB_CYCLES)) u_deb_conf (
    .clk    (clk),
    .rst    (rst),
    .raw    (conf_raw),
    .stable (conf_acc)
  );

  // Rising edge of the accepted confirm level
  always_ff @(posedge clk) begin
    if (rst) begin
      conf_acc_q <= 1'b0;
      conf_pulse <= 1'b0;
    end else begin
      conf_acc_q <= conf_acc;
      conf_pulse <= conf_acc & ~conf_acc_q;
    end
  end

endmodule

// File: tb/tb_io_board_endpoint.sv
// tb_io_board_endpoint: scoreboard bench for io_board_endpoint (SCAN_DIV=4, DEB_CYCLES=8).
// A reference model pushes time-stamped expectations; a monitor compares them with the DUT.
module tb_io_board_endpoint;

  localparam int SCAN_DIV   = 4;
  localparam int DEB_CYCLES = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        io_we;
  logic [31:0] io_wdata;
  logic [15:0] sw_raw;
  logic        conf_raw;
  logic [15:0] sw_data;
  logic        conf_pulse;
  logic [7:0]  tube_an;
  logic [7:0]  tube_seg;

  io_board_endpoint #(.SCAN_DIV(SCAN_DIV), .DEB_CYCLES(DEB_CYCLES)) dut (
    .clk        (clk),
    .rst        (rst),
    .io_we      (io_we),
    .io_wdata   (io_wdata),
    .sw_raw     (sw_raw),
    .conf_raw   (conf_raw),
    .sw_data    (sw_data),
    .conf_pulse (conf_pulse),
    .tube_an    (tube_an),
    .tube_seg   (tube_seg)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [7:0] an; logic [7:0] seg; } tube_e_t;
  typedef struct { int cyc; logic [15:0] val; } sw_e_t;

  tube_e_t tq[$];
  sw_e_t   swq[$];
  int      cq[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] glyph_tab [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  // ---------------- reference model state ----------------
  int          t;
  logic [31:0] disp_m, shown_val, pend_val;
  logic        shown_err;
  int          pend;
  logic [15:0] sw_h1, sw_h2, sw_run_val, sw_acc, sw_s2;
  int          sw_run;
  logic        c_h1, c_h2, c_run_val, c_acc, c_s2, c_pend;
  int          c_run;
  tube_e_t     te;
  sw_e_t       se;

  function automatic logic [7:0] exp_seg(input int idx);
`ifdef TUBE_DEC_EN
    logic [31:0] p;
    p = 32'd1;
    for (int i = 0; i < idx; i++) p = p * 32'd10;
    if (shown_err) return 8'h86;
    return glyph_tab[4'((shown_val / p) % 32'd10)];
`else
    return glyph_tab[4'(shown_val >> (4 * idx))];
`endif
  endfunction

  initial begin : model
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        t = 0;
        te.cyc = cyc; te.an = 8'hFE; te.seg = 8'hC0;
        tq.push_back(te);
        if (sw_acc != 16'h0) begin
          se.cyc = cyc; se.val = 16'h0;
          swq.push_back(se);
        end
        sw_acc = '0; sw_h1 = '0; sw_h2 = '0; sw_run_val = '0; sw_run = 0;
        c_acc = 1'b0; c_h1 = 1'b0; c_h2 = 1'b0; c_run_val = 1'b0; c_run = 0; c_pend = 1'b0;
        disp_m = '0; shown_val = '0; shown_err = 1'b0; pend = 0; pend_val = '0;
      end else begin
        // tube: digit (t/SCAN_DIV)%8 is lit, glyph from value shown before this edge
        t++;
        if (t % SCAN_DIV == 0) begin
          te.cyc = cyc;
          te.an  = ~(8'h01 << ((t / SCAN_DIV) % 8));
          te.seg = exp_seg((t / SCAN_DIV) % 8);
          tq.push_back(te);
        end
        // display value
`ifdef TUBE_DEC_EN
        if (io_we) begin
          disp_m = io_wdata; pend = 32; pend_val = io_wdata;
        end else if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            shown_val = pend_val;
            shown_err = pend_val > 32'd99_999_999;
          end
        end
`else
        if (io_we) disp_m = io_wdata;
        shown_val = disp_m;
`endif
        // switches: accept a value seen DEB_CYCLES times in a row after 2-cycle sync delay
        sw_s2 = sw_h2; sw_h2 = sw_h1; sw_h1 = sw_raw;
        if (sw_s2 == sw_run_val) sw_run++;
        else begin sw_run_val = sw_s2; sw_run = 1; end
        if (sw_s2 != sw_acc && sw_run >= DEB_CYCLES) begin
          sw_acc = sw_s2;
          se.cyc = cyc; se.val = sw_acc;
          swq.push_back(se);
        end
        // confirm: pulse on the edge after the accepted level rises
        if (c_pend) begin cq.push_back(cyc); c_pend = 1'b0; end
        c_s2 = c_h2; c_h2 = c_h1; c_h1 = conf_raw;
        if (c_s2 == c_run_val) c_run++;
        else begin c_run_val = c_s2; c_run = 1; end
        if (c_s2 != c_acc && c_run >= DEB_CYCLES) begin
          if (c_s2) c_pend = 1'b1;
          c_acc = c_s2;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  logic [15:0] last_sw = 16'h0;

  initial begin : monitor
    tube_e_t e;
    sw_e_t   s;
    int      c;
    forever begin
      @(negedge clk);
      while (tq.size() > 0 && tq[0].cyc <= cyc) begin
        e = tq.pop_front();
        checks++;
        if (e.cyc != cyc || tube_an !== e.an || tube_seg !== e.seg) begin
          errors++;
          $display("FAIL tube cyc=%0d got an=%h seg=%h want an=%h seg=%h (stamp %0d)",
                   cyc, tube_an, tube_seg, e.an, e.seg, e.cyc);
        end
      end
      if (sw_data !== last_sw) begin
        checks++;
        if (swq.size() == 0) begin
          errors++;
          $display("FAIL sw_unexpected cyc=%0d got %h want no change from %h", cyc, sw_data, last_sw);
        end else begin
          s = swq.pop_front();
          if (s.cyc != cyc || sw_data !== s.val) begin
            errors++;
            $display("FAIL sw_data cyc=%0d got %h want %h at cyc %0d", cyc, sw_data, s.val, s.cyc);
          end
        end
        last_sw = sw_data;
      end
      while (swq.size() > 0 && swq[0].cyc < cyc) begin
        s = swq.pop_front();
        checks++; errors++;
        $display("FAIL sw_missing cyc=%0d got %h want %h at cyc %0d", cyc, sw_data, s.val, s.cyc);
      end
      if (conf_pulse === 1'b1) begin
        checks++;
        if (cq.size() == 0) begin
          errors++;
          $display("FAIL conf_unexpected cyc=%0d got pulse want none", cyc);
        end else begin
          c = cq.pop_front();
          if (c != cyc) begin
            errors++;
            $display("FAIL conf_pulse cyc=%0d got pulse want it at cyc %0d", cyc, c);
          end
        end
      end
      while (cq.size() > 0 && cq[0] < cyc) begin
        c = cq.pop_front();
        checks++; errors++;
        $display("FAIL conf_missing cyc=%0d got no pulse want pulse at cyc %0d", cyc, c);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write(input logic [31:0] d);
    io_we = 1'b1; io_wdata = d;
    step(1);
    io_we = 1'b0;
  endtask

  initial begin : stim
    rst = 1'b1; io_we = 1'b0; io_wdata = '0; sw_raw = '0; conf_raw = 1'b0;
    step(3);
    rst = 1'b0;
    step(40);                                   // full scan of zeros
    write(32'h1234ABCD);
    step(40);
    io_we = 1'b1; io_wdata = 32'h0BADF00D; step(1);   // back-to-back, last wins
    io_wdata = 32'h76543210; step(1); io_we = 1'b0;
    step(40);
    sw_raw = 16'h00F0; step(20);
    sw_raw = 16'hFFFF; step(5);                 // short glitch
    sw_raw = 16'h00F0; step(20);
    conf_raw = 1'b1; step(40);
    conf_raw = 1'b0; step(20);
    for (int i = 0; i < 10; i++) begin           // bounce every 3 cycles
      conf_raw = ~conf_raw; step(3);
    end
    step(20);
    conf_raw = 1'b1; step(20);
    rst = 1'b1; io_we = 1'b1; io_wdata = 32'hDEADBEEF; step(1);   // write under reset
    io_we = 1'b0; step(2);
    rst = 1'b0; step(30);
    conf_raw = 1'b0; step(20);
    write(32'd12345678); step(45);
    write(32'd100000000); step(45);
    write(32'd87654321); step(10);
    write(32'd555); step(45);
    write(32'd99999999); step(45);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 11) == 0) sw_raw = 16'($urandom);
      if ($urandom_range(0, 9) == 0) conf_raw = ~conf_raw;
      if ($urandom_range(0, 15) == 0) begin
        io_we = 1'b1;
        io_wdata = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 99_999_999));
      end else begin
        io_we = 1'b0;
      end
      step(1);
    end
    io_we = 1'b0;
    step(60);
    #1;
    while (tq.size() > 0) begin
      te = tq.pop_front(); checks++; errors++;
      $display("FAIL tube_leftover stamp %0d got none want an=%h seg=%h", te.cyc, te.an, te.seg);
    end
    while (swq.size() > 0) begin
      se = swq.pop_front(); checks++; errors++;
      $display("FAIL sw_leftover stamp %0d got %h want %h", se.cyc, sw_data, se.val);
    end
    while (cq.size() > 0) begin
      checks++; errors++;
      $display("FAIL conf_leftover got no pulse want pulse at cyc %0d", cq.pop_front());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
